dm_write_buffer: RTL and testbench
==================================

Name: dm_write_buffer

Overview:
Posted-write buffer between the single-cycle CPU data-memory port and a slower handshaked data memory. CPU stores are queued and drained in order; loads that hit a queued store are forwarded in the same cycle. Loads that miss the queue go to memory, and the CPU is stalled until the data returns. The buffer sits directly downstream of the CPU's DM_Address / DM_enable / DM_Write_Data / DM_Read_Data port.

Parameters:
DATA_W, 32, data word width
ADDR_W, 16, word address width (matches CPU DM_Address)
DEPTH, 4, store entries; power of two, at least 2

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
cpu_addr  in  ADDR_W  word address from CPU
cpu_we  in  1  store request (CPU DM_enable)
cpu_re  in  1  load request
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data to CPU
cpu_stall  out  1  CPU must hold its current request and not advance the PC
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  one-cycle pulse: memory has completed the request
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack is high
buf_empty  out  1  no queued stores and FSM in IDLE

Behaviour:
- Reset: count, head and tail = 0; FSM = IDLE; rdata_q = 0. Outputs after reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0, buf_empty=1.
- Reset asserted mid-transaction: the in-flight request is abandoned and queued stores are discarded. mem_req=0 from the next edge. A late mem_ack is ignored.
- FIFO: circular buffer of {addr, data}. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Store accept: when cpu_we=1 and count<DEPTH, push on the edge.
  - cpu_stall=0 in that cycle.
  - If count==DEPTH, cpu_stall=1 and no push, even if a drain pop completes in the same cycle. The store is accepted on a later cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- If cpu_we and cpu_re are both 1, the request is treated as a store.
- Load forwarding: compare cpu_addr against all valid entries as they stand at the start of the cycle.
  - On a hit, cpu_rdata = data of the youngest matching entry, combinationally, and cpu_stall=0.
  - A store in the same cycle is never forwarded.
- FSM states: IDLE, WRITE, READ, RDONE.
  - IDLE: if cpu_re=1, cpu_we=0 and there is no hit (load miss), go to READ. Else if count>0, go to WRITE with the head entry. A load miss has priority over draining; ordering stays safe because a miss has no queued store to that address.
  - WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry, held stable until mem_ack. On mem_ack: pop the head and go to IDLE. A load miss arriving during WRITE stalls until the write acks.
  - READ: mem_req=1, mem_we=0, mem_addr = cpu_addr latched on entry, cpu_stall=1. On mem_ack: rdata_q <= mem_rdata and go to RDONE.
  - RDONE: cpu_rdata = rdata_q, cpu_stall=0, mem_req=0. Go to IDLE next cycle. The CPU consumes the load in this cycle.
- cpu_stall = (cpu_we & full) | (load miss while FSM is not RDONE).
- Latency:
  - Load hit: 0 cycles.
  - Load miss from IDLE: 1 + memory wait + 1 cycles.
  - Store: 0 cycles unless the buffer is full.
- Outside RDONE and forward hits, cpu_rdata = 0.
- mem_* outputs are registered from the FSM and entry state, so they have no combinational path from cpu_*.

Decomposition:
- Package dm_wb_pkg: FSM state enum (IDLE, WRITE, READ, RDONE) and default width/depth constants.
- Sub-module dm_wb_fifo: entry storage, head/tail/count, push/pop, and the parallel address compare with youngest-match select (outputs hit and hit_data).
- Top-level dm_write_buffer: FSM, stall logic and memory-side handshake.

Test Plan:
1. Reset, then store addr 0x0010 data 0xDEADBEEF with mem_ack 3 cycles after mem_req → no stall. mem_req/mem_we=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF held for 3 cycles, then buf_empty=1.
2. Hold mem_ack=0 and issue 5 stores (addr 1..5) → first 4 accepted, 5th sees cpu_stall=1. After the first ack, the 5th is accepted on the following cycle and count returns to 4.
3. Store 0x0020=0x11111111 then 0x0020=0x22222222 (no ack), then load 0x0020 → cpu_rdata=0x22222222 in the same cycle, cpu_stall=0.
4. Load 0x0030 with 2 queued stores and the FSM in IDLE → READ is issued before any drain. mem_rdata=0xCAFEF00D with ack after 2 cycles → RDONE cycle shows cpu_rdata=0xCAFEF00D, stall=0. Drains resume afterwards in order.
5. Load miss while a WRITE is in flight → stall through the write ack, then READ. Memory sees the write to completion before the read address.
6. Assert rst during READ with 3 queued stores → next cycle mem_req=0, cpu_stall=0, buf_empty=1. A stray mem_ack afterwards changes nothing.

Source files
------------

// File: rtl/dm_wb_pkg.sv
// Shared types and default sizing for the data-memory posted-write buffer.
package dm_wb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDepth = 4;

  // Memory-side sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StRdone
  } wb_state_e;

endpackage

// File: rtl/dm_wb_fifo.sv
// Circular store queue of {addr, data} with a parallel address lookup that
// returns the youngest matching entry for load forwarding.
module dm_wb_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o      = (count_q == CntW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign push_ok     = push_i & ~full_o;
  assign pop_ok      = pop_i & ~empty_o;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

  // Pointer and occupancy next state; simultaneous push and pop keeps count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (pop_ok)  head_d = head_q + 1'b1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < count_q) && (addr_q[head_q + PtrW'(i)] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[head_q + PtrW'(i)];
      end
    end
  end

endmodule

// File: rtl/dm_write_buffer.sv
// Posted-write buffer between the CPU data port and a handshaked data memory.
// Stores are queued and drained in order, loads hitting the queue are
// forwarded, and load misses stall the CPU until memory returns data.
module dm_write_buffer
  import dm_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_empty
);

  wb_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              fifo_full, fifo_empty, hit;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, hit_data;
  logic              load, load_miss, push, pop;

  // A simultaneous store and load is a store.
  assign load      = cpu_re & ~cpu_we;
  assign load_miss = load & ~hit;
  assign push      = cpu_we & ~fifo_full;
  assign pop       = (state_q == StWrite) & mem_ack;

  dm_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .pop_i         (pop),
    .push_addr_i   (cpu_addr),
    .push_data_i   (cpu_wdata),
    .lookup_addr_i (cpu_addr),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  // Sequencer next state; memory-side outputs are computed here and registered.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        // A miss has no queued store to its address, so reading first is safe.
        if (load_miss) begin
          state_d    = StRead;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_addr;
        end else if (!fifo_empty) begin
          state_d     = StWrite;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      StRead: begin
        if (mem_ack) begin
          state_d   = StRdone;
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata;
        end
      end
      StRdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and memory-side output registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Load data: returned read in RDONE, otherwise a forwarded queue hit.
  always_comb begin
    cpu_rdata = '0;
    if (state_q == StRdone) begin
      cpu_rdata = rdata_q;
    end else if (load && hit) begin
      cpu_rdata = hit_data;
    end
  end

  assign cpu_stall = (cpu_we & fifo_full) | (load_miss & (state_q != StRdone));
  assign buf_empty = fifo_empty & (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_write_buffer.sv
// Directed bench for dm_write_buffer with a queue-based reference model
// compared on every cycle, plus hand-computed expectations per scenario.
module tb_dm_write_buffer;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned DEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          buf_empty;

  logic          resp_ack = 1'b0;
  logic          stray_ack = 1'b0;
  logic [DW-1:0] rd_val = '0;
  bit            ack_en = 1'b1;
  int            ack_delay = 3;
  int            req_cnt = 0;
  bit            cmp_en = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model state: store queue (oldest first) and memory-side phase.
  logic [AW-1:0] mq_addr [$];
  logic [DW-1:0] mq_data [$];
  int            m_phase = 0;   // 0 idle, 1 writing, 2 reading, 3 read data returned
  logic [AW-1:0] m_raddr = '0;
  logic [DW-1:0] m_rdata = '0;

  // Completed memory transfers as {we, addr}.
  int unsigned mlog [$];

  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = rd_val;

  always #5 clk = ~clk;

  dm_write_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .buf_empty (buf_empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_lookup(input logic [AW-1:0] a, output logic [DW-1:0] d);
    d = '0;
    for (int i = mq_addr.size() - 1; i >= 0; i--) begin
      if (mq_addr[i] == a) begin
        d = mq_data[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Memory responder: acks after the request has been up ack_delay cycles.
  always @(posedge clk) begin : responder
    #1;
    if (mem_req && !resp_ack) begin
      req_cnt++;
      if (ack_en && req_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        req_cnt  = 0;
      end
    end else begin
      resp_ack = 1'b0;
      if (!mem_req) req_cnt = 0;
    end
  end

  // Model advance on each rising edge from the inputs seen during the cycle.
  always @(posedge clk) begin : model_upd
    bit            hit, full, miss;
    logic [DW-1:0] hd;
    if (rst) begin
      mq_addr.delete();
      mq_data.delete();
      m_phase = 0;
      m_rdata = '0;
    end else begin
      hit  = model_lookup(cpu_addr, hd);
      full = (mq_addr.size() == DEP);
      miss = cpu_re && !cpu_we && !hit;
      case (m_phase)
        0: begin
          if (miss) begin
            m_phase = 2;
            m_raddr = cpu_addr;
          end else if (mq_addr.size() > 0) begin
            m_phase = 1;
          end
        end
        1: if (mem_ack) begin
          m_phase = 0;
          void'(mq_addr.pop_front());
          void'(mq_data.pop_front());
        end
        2: if (mem_ack) begin
          m_phase = 3;
          m_rdata = mem_rdata;
        end
        default: m_phase = 0;
      endcase
      if (cpu_we && !full) begin
        mq_addr.push_back(cpu_addr);
        mq_data.push_back(cpu_wdata);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit            hit, load, miss, e_stall, e_req, e_we, e_empty;
    logic [DW-1:0] hd, e_rdata;
    if (cmp_en) begin
      hit     = model_lookup(cpu_addr, hd);
      load    = cpu_re && !cpu_we;
      miss    = load && !hit;
      e_stall = (cpu_we && mq_addr.size() == DEP) || (miss && m_phase != 3);
      e_rdata = (m_phase == 3) ? m_rdata : ((load && hit) ? hd : '0);
      e_req   = (m_phase == 1) || (m_phase == 2);
      e_we    = (m_phase == 1);
      e_empty = (mq_addr.size() == 0) && (m_phase == 0);
      chk("cmp_cpu_stall", cpu_stall, e_stall);
      chk("cmp_cpu_rdata", cpu_rdata, e_rdata);
      chk("cmp_mem_req", mem_req, e_req);
      chk("cmp_mem_we", mem_we, e_we);
      chk("cmp_buf_empty", buf_empty, e_empty);
      if (m_phase == 1) begin
        chk("cmp_mem_addr_wr", mem_addr, mq_addr[0]);
        chk("cmp_mem_wdata", mem_wdata, mq_data[0]);
      end else if (m_phase == 2) begin
        chk("cmp_mem_addr_rd", mem_addr, m_raddr);
      end
      if (mem_req && mem_ack) mlog.push_back({15'b0, mem_we, mem_addr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input bit we, input bit re, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    cpu_we = we;
    cpu_re = re;
    cpu_addr = a;
    cpu_wdata = d;
  endtask

  // Idle the CPU until the buffer is empty; returns at a falling edge.
  task automatic drain();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 60; i++) begin
      sample();
      if (buf_empty) return;
      tick();
    end
    chk("drain_timeout", buf_empty, 1);
  endtask

  task automatic chk_log(input string nm, input int idx, input int unsigned exp);
    if (idx < mlog.size()) chk(nm, mlog[idx], exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Reset
    tick();
    cmp_en = 1'b1;
    sample();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_buf_empty", buf_empty, 1);
    tick();
    rst = 1'b0;

    // 1: single store, write held three cycles until ack
    ack_en = 1'b1; ack_delay = 3; mlog.delete();
    drive(1'b1, 1'b0, 16'h0010, 32'hDEADBEEF);
    sample();
    chk("t1_store_stall", cpu_stall, 0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (mem_req) begin
        n++;
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 16'h0010);
        chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end else if (n > 0 && buf_empty) begin
        break;
      end
      tick();
    end
    chk("t1_req_cycles", n, 3);
    chk("t1_buf_empty", buf_empty, 1);
    chk("t1_log_len", mlog.size(), 1);
    chk_log("t1_log0", 0, 32'h1_0010);
    tick();

    // 2: fill to DEPTH with memory stalled; fifth store waits for a pop
    ack_en = 1'b0; mlog.delete();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, AW'(i), DW'(32'h100 + i));
      sample();
      if (i < 5) chk("t2_accept_stall", cpu_stall, 0);
      else       chk("t2_full_stall", cpu_stall, 1);
      if (i < 5) tick();
    end
    ack_en = 1'b1; ack_delay = 1;
    tick();
    sample();
    chk("t2_ack_now", mem_ack, 1);
    chk("t2_stall_during_pop", cpu_stall, 1);
    tick();
    sample();
    chk("t2_accept_after_pop", cpu_stall, 0);
    tick();
    drain();
    tick();
    chk("t2_log_len", mlog.size(), 5);
    for (int i = 0; i < 5; i++) chk_log("t2_log", i, 32'h1_0000 + i + 1);

    // 3: forwarding picks the youngest match; a store+load is not forwarded
    ack_en = 1'b0;
    drive(1'b1, 1'b0, 16'h0020, 32'h11111111); sample(); tick();
    drive(1'b1, 1'b0, 16'h0020, 32'h22222222); sample(); tick();
    drive(1'b0, 1'b1, 16'h0020, '0);
    sample();
    chk("t3_fwd_data", cpu_rdata, 32'h22222222);
    chk("t3_fwd_stall", cpu_stall, 0);
    tick();
    drive(1'b1, 1'b1, 16'h0020, 32'h33333333);
    sample();
    chk("t3_we_re_no_fwd", cpu_rdata, 0);
    chk("t3_we_re_stall", cpu_stall, 0);
    tick();
    drive(1'b0, 1'b1, 16'h0020, '0);
    sample();
    chk("t3_fwd_youngest", cpu_rdata, 32'h33333333);
    ack_en = 1'b1; ack_delay = 1;
    tick();
    drain();
    tick();

    // 4: load miss from IDLE with queued stores goes to memory first
    ack_en = 1'b0; mlog.delete();
    drive(1'b1, 1'b0, 16'h0040, 32'hA1); sample(); tick();
    drive(1'b1, 1'b0, 16'h0041, 32'hA2); sample(); tick();
    drive(1'b1, 1'b0, 16'h0042, 32'hA3); sample(); tick();
    drive(1'b0, 1'b0, '0, '0); sample();
    ack_en = 1'b1; ack_delay = 1;
    tick();
    sample();
    chk("t4_write_ack", mem_ack, 1);
    ack_delay = 2; rd_val = 32'hCAFEF00D;
    tick();
    drive(1'b0, 1'b1, 16'h0030, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!cpu_stall) break;
      if (n == 1) begin
        chk("t4_rd_req", mem_req, 1);
        chk("t4_rd_we", mem_we, 0);
        chk("t4_rd_addr", mem_addr, 16'h0030);
      end
      n++;
      tick();
    end
    chk("t4_stall_cycles", n, 3);
    chk("t4_rdone_data", cpu_rdata, 32'hCAFEF00D);
    tick();
    drain();
    tick();
    chk("t4_log_len", mlog.size(), 4);
    chk_log("t4_log0", 0, 32'h1_0040);
    chk_log("t4_log1", 1, 32'h0_0030);
    chk_log("t4_log2", 2, 32'h1_0041);
    chk_log("t4_log3", 3, 32'h1_0042);

    // 5: load miss during a write stalls through the write, then reads
    ack_en = 1'b1; ack_delay = 3; rd_val = 32'h60606060; mlog.delete();
    drive(1'b1, 1'b0, 16'h0050, 32'h55555555); sample(); tick();
    drive(1'b0, 1'b0, '0, '0); sample(); tick();
    drive(1'b0, 1'b1, 16'h0060, '0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      sample();
      if (!cpu_stall) break;
      n++;
      tick();
    end
    chk("t5_stall_cycles", n, 7);
    chk("t5_rdone_data", cpu_rdata, 32'h60606060);
    tick();
    drain();
    tick();
    chk("t5_log_len", mlog.size(), 2);
    chk_log("t5_log0", 0, 32'h1_0050);
    chk_log("t5_log1", 1, 32'h0_0060);

    // 6: reset during a read with three queued stores, then a stray ack
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, AW'(16'h0070 + i), DW'(32'h70000000 + i));
      sample();
      tick();
    end
    drive(1'b0, 1'b0, '0, '0); sample();
    ack_en = 1'b1; ack_delay = 1;
    tick();
    sample();
    chk("t6_write_ack", mem_ack, 1);
    ack_en = 1'b0;
    tick();
    drive(1'b0, 1'b1, 16'h0080, '0);
    sample();
    chk("t6_miss_stall", cpu_stall, 1);
    tick();
    sample();
    chk("t6_read_req", mem_req, 1);
    chk("t6_read_we", mem_we, 0);
    tick();
    sample();
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    sample();
    tick();
    rst = 1'b0;
    sample();
    chk("t6_post_rst_req", mem_req, 0);
    chk("t6_post_rst_stall", cpu_stall, 0);
    chk("t6_post_rst_empty", buf_empty, 1);
    tick();
    stray_ack = 1'b1;
    sample();
    tick();
    stray_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t6_stray_req", mem_req, 0);
      chk("t6_stray_empty", buf_empty, 1);
      chk("t6_stray_rdata", cpu_rdata, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
